if_id_buffer: RTL



---
 rtl/if_id_buffer_pkg.sv | 18 +
 rtl/if_id_buffer.sv | 104 ++++++++++
 2 files changed

// File: rtl/if_id_buffer_pkg.sv
// Shared fetch/decode definitions: bus widths, reset polarity and the NOP encoding.
package if_id_buffer_pkg;

    // Instruction word width.
    localparam int INST_BUS_W      = 32;
    // Instruction address (PC) width.
    localparam int INST_ADDR_BUS_W = 32;
    // Reset is active-high.
    localparam logic RST_ENABLE    = 1'b1;
    // addi x0,x0,0 -- shown to decode whenever nothing valid is queued.
    localparam logic [INST_BUS_W-1:0] INST_NOP = 32'h0000_0013;

    // Pointer width for a queue of the given depth.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/if_id_buffer.sv
// IF/ID decoupling queue: captures fetched {pc, inst} pairs in order and
// presents the oldest one to decode over a valid/ready handshake.
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int                    DEPTH = 2,
    parameter int                    AW    = INST_ADDR_BUS_W,
    parameter logic [INST_BUS_W-1:0] NOP   = INST_NOP
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         if_valid_i,
    output logic                         if_ready_o,
    input  logic [AW-1:0]                if_pc_i,
    input  logic [INST_BUS_W-1:0]        if_inst_i,
    output logic                         id_valid_o,
    input  logic                         id_ready_i,
    output logic [AW-1:0]                id_pc_o,
    output logic [INST_BUS_W-1:0]        id_inst_o,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [PW-1:0]         wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]         rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]         count_reg, count_next;
    logic                  push, pop;

    logic [AW-1:0]         pc_mem   [DEPTH];
    logic [INST_BUS_W-1:0] inst_mem [DEPTH];

    // Handshake flags come only from registered occupancy, so if_ready_o has
    // no combinational path from id_ready_i.
    assign if_ready_o = (count_reg != CW'(DEPTH));
    assign id_valid_o = (count_reg != '0);
    assign push       = if_valid_i & if_ready_o;
    assign pop        = id_valid_o & id_ready_i;
    assign count_o    = count_reg;

    // Head entry toward decode; an empty queue shows pc 0 and a NOP.
    assign id_pc_o    = id_valid_o ? pc_mem[rd_ptr_reg]   : '0;
    assign id_inst_o  = id_valid_o ? inst_mem[rd_ptr_reg] : NOP;

    // One flop-based storage slot per entry, written when the write pointer selects it.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [AW-1:0]         pc_reg;
            logic [INST_BUS_W-1:0] inst_reg;

            // Capture the fetched pair into this slot; contents need no reset.
            always_ff @(posedge clk) begin
                if (push && !flush_i && (wr_ptr_reg == PW'(gi))) begin
                    pc_reg   <= if_pc_i;
                    inst_reg <= if_inst_i;
                end
            end

            assign pc_mem[gi]   = pc_reg;
            assign inst_mem[gi] = inst_reg;
        end
    endgenerate

    // Next pointer/occupancy: flush wins over push and pop, otherwise both may advance.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush_i) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // Pointer and occupancy registers; reset clears them immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

endmodule
